// File: rtl/spi_slave_if.sv
// SPI slave with clk-domain oversampling: 32-bit LSB-first word mode (spi_frame low)
// and single-byte OOB mode (spi_cs low, spi_frame high), with valid/ready transmit fetch.
module spi_slave_if #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] TX_IDLE     = 32'hFFFF_FFFF,
  parameter logic [7:0]  OOB_IDLE    = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic        spi_cs,
  input  logic        spi_frame,
  output logic [31:0] rx_word,
  output logic        rx_word_valid,
  output logic [7:0]  rx_oob,
  output logic        rx_oob_valid,
  output logic        rx_abort,
  input  logic [31:0] tx_word,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx_underrun,
  input  logic [7:0]  tx_oob,
  input  logic        tx_oob_wr
);

  typedef enum logic [1:0] {S_IDLE, S_WORD, S_OOB} state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync, frame_sync;
  logic        sclk_s, mosi_s, cs_s, frame_s, sclk_d, rise;
  logic [4:0]  bitcnt;
  logic [30:0] rx_sh;
  logic [31:0] tx_sh;
  logic [7:0]  oob_buf;
  logic        oob_pend;
  logic        word_load, oob_load, word_done, oob_done, abort, shift_en;

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign frame_s = frame_sync[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_d;

  // Chains preset to the idle bus levels so reset release cannot fake an edge or a select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync  <= '0;
      mosi_sync  <= '0;
      cs_sync    <= '1;
      frame_sync <= '1;
      sclk_d     <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      frame_sync <= {frame_sync[SYNC_STAGES-2:0], spi_frame};
      sclk_d     <= sclk_s;
    end
  end

  always_comb begin
    next_state = state;
    word_load  = 1'b0;
    oob_load   = 1'b0;
    word_done  = 1'b0;
    oob_done   = 1'b0;
    abort      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!frame_s) begin
          next_state = S_WORD;
          word_load  = 1'b1;
        end else if (!cs_s) begin
          next_state = S_OOB;
          oob_load   = 1'b1;
        end
      end
      S_WORD: begin
        if (frame_s) begin
          next_state = S_IDLE;
          abort      = (bitcnt != 5'd0);
        end else if (rise && bitcnt == 5'd31) begin
          word_done = 1'b1;
          word_load = 1'b1;
        end
      end
      S_OOB: begin
        if (!frame_s) begin
          next_state = S_WORD;
          abort      = (bitcnt != 5'd0);
          word_load  = 1'b1;
        end else if (cs_s) begin
          next_state = S_IDLE;
          abort      = (bitcnt != 5'd0);
        end else if (rise && bitcnt == 5'd7) begin
          oob_done = 1'b1;
          oob_load = 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase
    shift_en = rise && (next_state == state) && (state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      bitcnt        <= '0;
      rx_sh         <= '0;
      tx_sh         <= '0;
      oob_buf       <= '0;
      oob_pend      <= 1'b0;
      rx_word       <= '0;
      rx_word_valid <= 1'b0;
      rx_oob        <= '0;
      rx_oob_valid  <= 1'b0;
      rx_abort      <= 1'b0;
      tx_ready      <= 1'b0;
      tx_underrun   <= 1'b0;
    end else begin
      state         <= next_state;
      rx_word_valid <= 1'b0;
      rx_oob_valid  <= 1'b0;
      tx_ready      <= 1'b0;
      tx_underrun   <= 1'b0;
      rx_abort      <= abort;
      if (shift_en) begin
        rx_sh  <= {mosi_s, rx_sh[30:1]};
        tx_sh  <= {1'b0, tx_sh[31:1]};
        bitcnt <= bitcnt + 5'd1;
      end
      if (word_done) begin
        rx_word       <= {mosi_s, rx_sh};
        rx_word_valid <= 1'b1;
      end
      if (oob_done) begin
        rx_oob       <= {mosi_s, rx_sh[30:24]};
        rx_oob_valid <= 1'b1;
      end
      if (word_load) begin
        bitcnt <= '0;
        if (tx_valid) begin
          tx_sh    <= tx_word;
          tx_ready <= 1'b1;
        end else begin
          tx_sh       <= TX_IDLE;
          tx_underrun <= 1'b1;
        end
      end
      if (oob_load) begin
        bitcnt   <= '0;
        tx_sh    <= {24'h0, (oob_pend ? oob_buf : OOB_IDLE)};
        oob_pend <= 1'b0;
      end
      if (next_state == S_IDLE)
        bitcnt <= '0;
      // A write landing on a byte-start load re-arms pending, so it goes out with the next byte.
      if (tx_oob_wr) begin
        oob_buf  <= tx_oob;
        oob_pend <= 1'b1;
      end
    end
  end

  assign spi_miso = (state != S_IDLE) & tx_sh[0];

endmodule

// File: tb/tb_spi_slave_if.sv
// Randomized bench for spi_slave_if: bit-banged SPI master plus a queue-based model
// of transmit fetch, OOB pending byte and received-data order.
`timescale 1ns/1ps
module tb_spi_slave_if;

  localparam int HALF = 20;
  localparam logic [31:0] TX_IDLE  = 32'hFFFF_FFFF;
  localparam logic [7:0]  OOB_IDLE = 8'hFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        spi_cs = 1'b1;
  logic        spi_frame = 1'b1;
  logic [31:0] rx_word;
  logic        rx_word_valid;
  logic [7:0]  rx_oob;
  logic        rx_oob_valid;
  logic        rx_abort;
  logic [31:0] tx_word = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        tx_underrun;
  logic [7:0]  tx_oob = '0;
  logic        tx_oob_wr = 1'b0;

  spi_slave_if #(.SYNC_STAGES(2), .TX_IDLE(TX_IDLE), .OOB_IDLE(OOB_IDLE)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_cs(spi_cs), .spi_frame(spi_frame), .rx_word(rx_word), .rx_word_valid(rx_word_valid),
    .rx_oob(rx_oob), .rx_oob_valid(rx_oob_valid), .rx_abort(rx_abort), .tx_word(tx_word),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_underrun(tx_underrun), .tx_oob(tx_oob),
    .tx_oob_wr(tx_oob_wr)
  );

  always #2.5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transmit words offered to the DUT; the monitor advances tx_rd on each tx_ready.
  logic [31:0] tx_q[$];
  int unsigned tx_rd = 0;
  logic [31:0] rx_q[$];
  logic [7:0]  oob_q[$];
  int unsigned ready_cnt = 0, under_cnt = 0, abort_cnt = 0, both_cnt = 0;

  always @(negedge clk) begin : monitor
    int unsigned nxt;
    nxt = tx_rd + (tx_ready ? 1 : 0);
    tx_rd    <= nxt;
    tx_valid <= (nxt < tx_q.size());
    tx_word  <= (nxt < tx_q.size()) ? tx_q[nxt] : 32'h0;
    if (rx_word_valid) rx_q.push_back(rx_word);
    if (rx_oob_valid) oob_q.push_back(rx_oob);
    if (tx_ready) ready_cnt <= ready_cnt + 1;
    if (tx_underrun) under_cnt <= under_cnt + 1;
    if (rx_abort) abort_cnt <= abort_cnt + 1;
    if (rx_word_valid && rx_oob_valid) both_cnt <= both_cnt + 1;
  end

  logic        oob_pend_m = 1'b0;
  logic [7:0]  oob_val_m = '0;
  logic [31:0] wbuf[4];
  logic [7:0]  bbuf[4];

  task automatic spi_xfer(input logic [31:0] dout, input int unsigned n, output logic [31:0] din);
    din = '0;
    for (int unsigned i = 0; i < n; i++) begin
      spi_mosi = dout[i];
      #HALF;
      din[i] = spi_miso;
      spi_clk = 1'b1;
      #HALF;
      spi_clk = 1'b0;
    end
  endtask

  task automatic oob_write(input logic [7:0] v);
    @(negedge clk);
    tx_oob = v;
    tx_oob_wr = 1'b1;
    @(negedge clk);
    tx_oob_wr = 1'b0;
    oob_pend_m = 1'b1;
    oob_val_m = v;
  endtask

  // Every word start (entry and each boundary) takes the next offered word or TX_IDLE;
  // the fetch at the final boundary is lost when the frame closes.
  task automatic word_frame(input int unsigned n);
    logic [31:0] mq[$];
    logic [31:0] got, exp;
    int unsigned er, eu, r0, u0, a0, base;
    repeat (2) @(negedge clk);
    mq.delete();
    for (int unsigned i = tx_rd; i < tx_q.size(); i++) mq.push_back(tx_q[i]);
    er = 0; eu = 0; r0 = ready_cnt; u0 = under_cnt; a0 = abort_cnt; base = rx_q.size();
    spi_frame = 1'b0;
    #HALF;
    for (int unsigned k = 0; k < n; k++) begin
      if (mq.size() != 0) begin exp = mq.pop_front(); er++; end
      else begin exp = TX_IDLE; eu++; end
      spi_xfer(wbuf[k], 32, got);
      check("miso_word", got, exp);
    end
    if (mq.size() != 0) er++; else eu++;
    #HALF;
    spi_frame = 1'b1;
    repeat (10) @(negedge clk);
    check("rx_word_cnt", rx_q.size() - base, n);
    for (int unsigned k = 0; k < n; k++)
      if (base + k < rx_q.size()) check("rx_word", rx_q[base + k], wbuf[k]);
    check("tx_ready_cnt", ready_cnt - r0, er);
    check("tx_underrun_cnt", under_cnt - u0, eu);
    check("no_abort_word", abort_cnt - a0, 0);
  endtask

  task automatic oob_frame(input int unsigned n);
    logic [31:0] got;
    logic [7:0]  exp;
    int unsigned a0, base, wbase;
    repeat (2) @(negedge clk);
    a0 = abort_cnt; base = oob_q.size(); wbase = rx_q.size();
    spi_cs = 1'b0;
    #HALF;
    for (int unsigned k = 0; k < n; k++) begin
      exp = oob_pend_m ? oob_val_m : OOB_IDLE;
      oob_pend_m = 1'b0;
      spi_xfer({24'h0, bbuf[k]}, 8, got);
      check("miso_oob", got, {24'h0, exp});
    end
    #HALF;
    spi_cs = 1'b1;
    repeat (10) @(negedge clk);
    check("rx_oob_cnt", oob_q.size() - base, n);
    for (int unsigned k = 0; k < n; k++)
      if (base + k < oob_q.size()) check("rx_oob", {24'h0, oob_q[base + k]}, {24'h0, bbuf[k]});
    check("no_word_in_oob", rx_q.size() - wbase, 0);
    check("no_abort_oob", abort_cnt - a0, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    logic [31:0] got, exp;
    int unsigned a0, base, obase;

    #2 rst = 1'b1;
    #1;
    check("rst_pulses_miso", {26'h0, rx_word_valid, rx_oob_valid, rx_abort, tx_ready, tx_underrun, spi_miso}, 32'h0);
    check("rst_rx_word", rx_word, 32'h0);
    check("rst_rx_oob", {24'h0, rx_oob}, 32'h0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Word mode, one word with one offered tx word.
    tx_q.push_back(32'hA5A5_0F0F);
    wbuf[0] = 32'h1234_5678;
    word_frame(1);

    // Back-to-back words with nothing offered.
    wbuf[0] = 32'hDEAD_BEEF;
    wbuf[1] = 32'h0000_0001;
    word_frame(2);

    // OOB with and without a pending byte.
    oob_write(8'h3C);
    bbuf[0] = 8'hC3;
    bbuf[1] = 8'h96;
    oob_frame(2);

    // Frame released after 12 bits.
    repeat (2) @(negedge clk);
    a0 = abort_cnt; base = rx_q.size();
    spi_frame = 1'b0;
    #HALF;
    spi_xfer($urandom, 12, got);
    #HALF;
    spi_frame = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_pulse", abort_cnt - a0, 1);
    check("abort_no_rx", rx_q.size() - base, 0);
    wbuf[0] = 32'h0BAD_F00D;
    word_frame(1);

    // Asynchronous reset at bit 17 of a word.
    repeat (2) @(negedge clk);
    exp = (tx_rd < tx_q.size()) ? tx_q[tx_rd] : TX_IDLE;
    base = rx_q.size();
    spi_frame = 1'b0;
    #HALF;
    spi_xfer(32'h1357_9BDF, 17, got);
    check("miso_pre_rst", {31'h0, spi_miso}, {31'h0, exp[17]});
    #3 rst = 1'b1;
    #1;
    check("arst_pulses_miso", {26'h0, rx_word_valid, rx_oob_valid, rx_abort, tx_ready, tx_underrun, spi_miso}, 32'h0);
    check("arst_rx_word", rx_word, 32'h0);
    check("arst_rx_oob", {24'h0, rx_oob}, 32'h0);
    #10 spi_frame = 1'b1;
    oob_pend_m = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("arst_no_rx", rx_q.size() - base, 0);
    wbuf[0] = 32'h5555_AAAA;
    word_frame(1);

    // OOB byte then frame falls at the byte boundary.
    oob_write(8'h5A);
    repeat (2) @(negedge clk);
    a0 = abort_cnt; base = rx_q.size(); obase = oob_q.size();
    exp = (tx_rd < tx_q.size()) ? tx_q[tx_rd] : TX_IDLE;
    spi_cs = 1'b0;
    #HALF;
    spi_xfer(32'h0000_0081, 8, got);
    check("miso_oob_then_word", got, 32'h0000_005A);
    oob_pend_m = 1'b0;
    #HALF;
    spi_frame = 1'b0;
    #HALF;
    wbuf[0] = $urandom;
    spi_xfer(wbuf[0], 32, got);
    check("miso_word_after_oob", got, exp);
    #HALF;
    spi_frame = 1'b1;
    spi_cs = 1'b1;
    repeat (10) @(negedge clk);
    check("oob_then_word_oob_cnt", oob_q.size() - obase, 1);
    if (obase < oob_q.size()) check("oob_then_word_oob", {24'h0, oob_q[obase]}, 32'h81);
    check("oob_then_word_word_cnt", rx_q.size() - base, 1);
    if (base < rx_q.size()) check("oob_then_word_word", rx_q[base], wbuf[0]);
    check("oob_then_word_no_abort", abort_cnt - a0, 0);

    // Randomized frames.
    for (int it = 0; it < 5; it++) begin
      int unsigned nw, np, nb;
      nw = $urandom_range(1, 3);
      np = $urandom_range(0, 3);
      for (int unsigned k = 0; k < nw; k++) wbuf[k] = $urandom;
      for (int unsigned k = 0; k < np; k++) tx_q.push_back($urandom);
      word_frame(nw);
      if ($urandom_range(0, 1) == 1) oob_write(8'($urandom));
      nb = $urandom_range(1, 3);
      for (int unsigned k = 0; k < nb; k++) bbuf[k] = 8'($urandom);
      oob_frame(nb);
    end

    check("valid_overlap", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
